// File: rtl/n_b2_serial_adder_pkg.sv
// Shared definitions for the bit-serial base-2 adder: FSM state encoding and
// a helper that sizes the digit counter.
package n_b2_serial_adder_pkg;

  // Controller states; encodings are fixed so they can be observed externally.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Digit counter width: clog2(n), but never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/n_b2_serial_adder_b2_adder.sv
// Single base-2 digit cell (full adder). Its interface mirrors b2_subtractor
// so the serial adder and the ripple subtractors share the same cell shape.
module b2_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/n_b2_serial_adder.sv
// Bit-serial N-digit base-2 adder. Operands are captured on the input
// handshake, then one digit is added per clock (LSB first) through a single
// b2_adder cell and a carry flip-flop. The result is held until the consumer
// takes it, so the producer and consumer sides are fully decoupled.
module n_b2_serial_adder
  import n_b2_serial_adder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = cnt_width(N);

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_x_sh;
  logic [N-1:0]    r_y_sh;
  logic [N-1:0]    r_s;
  logic            r_carry;
  logic            r_cout;
  logic [CW-1:0]   r_cnt;

  logic            w_d;
  logic            w_c;
  logic            w_last;
  logic [N:0]      w_s_cat;

  // The one digit cell, fed by the low digits of the operand shift registers.
  b2_adder u_b2_adder (
    .x    (r_x_sh[0]),
    .y    (r_y_sh[0]),
    .cin  (r_carry),
    .s    (w_d),
    .cout (w_c)
  );

  assign w_last  = (r_cnt == CW'(N - 1));
  // New digit enters at the MSB; taking [N:1] shifts right and also works for N=1.
  assign w_s_cat = {w_d, r_s};

  assign s    = r_s;
  assign cout = r_cout;

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments in clocked blocks keep every register
    // updating from the same pre-edge values, so ordering of statements never matters.
    if (!reset_) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand load, digit-serial shifting, carry and result capture.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_x_sh  <= '0;
      r_y_sh  <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x_sh  <= x;
            r_y_sh  <= y;
            r_carry <= cin;
            r_s     <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_s     <= w_s_cat[N:1];
          r_x_sh  <= r_x_sh >> 1;
          r_y_sh  <= r_y_sh >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_cout <= w_c;
        end
        default: ;  // DONE holds s/cout until handoff; they persist into IDLE.
      endcase
    end
  end

endmodule

// File: tb/tb_n_b2_serial_adder.sv
// Bench for n_b2_serial_adder: directed N=3 vectors (basic sum, wrap-around,
// backpressure, in_valid during RUN, reset abort) and an N=8 random sweep
// with random consumer backpressure.
module tb_n_b2_serial_adder;

  logic       clk = 1'b0;
  logic       reset_;

  // N=3 instance
  logic [2:0] x3, y3, s3;
  logic       cin3, iv3, ir3, co3, ov3, or3;
  // N=8 instance
  logic [7:0] x8, y8, s8;
  logic       cin8, iv8, ir8, co8, ov8, or8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  n_b2_serial_adder #(.N(3)) u_dut3 (
    .clock(clk), .reset_(reset_), .x(x3), .y(y3), .cin(cin3),
    .in_valid(iv3), .in_ready(ir3), .s(s3), .cout(co3),
    .out_valid(ov3), .out_ready(or3)
  );

  n_b2_serial_adder #(.N(8)) u_dut8 (
    .clock(clk), .reset_(reset_), .x(x8), .y(y8), .cin(cin8),
    .in_valid(iv8), .in_ready(ir8), .s(s8), .cout(co8),
    .out_valid(ov8), .out_ready(or8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until out_valid rises or the bound expires; returns edges taken.
  task automatic wait_ov3(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!ov3 && cyc < 50);
  endtask

  task automatic wait_ov8(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!ov8 && cyc < 50);
  endtask

  // One N=3 transaction: accept, check latency/result, hold backpressure for
  // bp cycles, hand off. With hold set, in_valid stays high with different
  // operands throughout RUN and must be ignored.
  task automatic run3(input string tag, input logic [2:0] x, input logic [2:0] y,
                      input logic c, input logic [2:0] es, input logic ec,
                      input int bp, input bit hold);
    int cyc;
    x3 = x; y3 = y; cin3 = c; iv3 = 1'b1; or3 = 1'b0;
    check({tag, ".in_ready"}, ir3, 1);
    tick();
    if (hold) begin x3 = ~x; y3 = ~y; cin3 = ~c; end
    else iv3 = 1'b0;
    wait_ov3(cyc);
    iv3 = 1'b0;
    check({tag, ".latency"}, cyc, 3);
    check({tag, ".sum"}, {ov3, co3, s3}, {1'b1, ec, es});
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, ".hold"}, {ov3, ir3, co3, s3}, {1'b1, 1'b0, ec, es});
    end
    or3 = 1'b1;
    tick();
    or3 = 1'b0;
    check({tag, ".handoff"}, {ov3, ir3, co3, s3}, {1'b0, 1'b1, ec, es});
  endtask

  initial begin
    int cyc;
    logic [8:0] exp9;
    logic [7:0] rx, ry;
    logic       rc;

    reset_ = 1'b0;
    x3 = '0; y3 = '0; cin3 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
    x8 = '0; y8 = '0; cin8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    tick(); tick();
    check("reset3", {ir3, ov3, co3, s3}, {1'b1, 1'b0, 1'b0, 3'b000});
    check("reset8", {ir8, ov8, co8, s8}, {1'b1, 1'b0, 1'b0, 8'h00});
    reset_ = 1'b1;
    tick();

    // Directed N=3 vectors (hand-computed)
    run3("t1_101+010",   3'b101, 3'b010, 1'b0, 3'b111, 1'b0, 0, 1'b0);
    run3("t2_111+001",   3'b111, 3'b001, 1'b0, 3'b000, 1'b1, 0, 1'b0);
    run3("t2_111+111+1", 3'b111, 3'b111, 1'b1, 3'b111, 1'b1, 0, 1'b0);
    run3("t3_backpress", 3'b010, 3'b011, 1'b1, 3'b110, 1'b0, 5, 1'b0);
    run3("t4_ivhold",    3'b011, 3'b001, 1'b0, 3'b100, 1'b0, 1, 1'b1);

    // Reset in the second RUN cycle aborts the operation.
    x3 = 3'b111; y3 = 3'b000; cin3 = 1'b0; iv3 = 1'b1;
    tick();                 // accepted, first RUN cycle
    iv3 = 1'b0;
    tick();                 // second RUN cycle, one digit already in s
    reset_ = 1'b0;
    tick();
    check("t5_abort", {ir3, ov3, co3, s3}, {1'b1, 1'b0, 1'b0, 3'b000});
    reset_ = 1'b1;
    tick();
    run3("t5_after",     3'b110, 3'b011, 1'b0, 3'b001, 1'b1, 0, 1'b0);

    // N=8 random sweep with random out_ready.
    for (int t = 0; t < 200; t++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp9 = {1'b0, rx} + {1'b0, ry} + {8'h00, rc};
      cyc = 0;
      while (!ir8 && cyc < 50) begin tick(); cyc++; end
      x8 = rx; y8 = ry; cin8 = rc; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      or8 = 1'($urandom_range(0, 1));   // ignored while running
      wait_ov8(cyc);
      check("t6_latency", cyc, 8);
      check("t6_sum", {ov8, co8, s8}, {1'b1, exp9});
      cyc = 0;
      do begin
        or8 = 1'($urandom_range(0, 1));
        tick();
        cyc++;
        if (!or8) check("t6_hold", {ov8, co8, s8}, {1'b1, exp9});
      end while (!or8 && cyc < 20);
      if (!or8) begin
        or8 = 1'b1;
        tick();
      end
      or8 = 1'b0;
      check("t6_handoff", {ov8, ir8}, {1'b0, 1'b1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
